// File: rtl/mau_host_bridge_pkg.sv
// rtl/mau_host_bridge_pkg.sv - shared state encoding and opcode classes for the matrix-unit host bridge
package mau_bridge_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FILL,
        ST_ISSUE,
        ST_STREAM,
        ST_CAPTURE,
        ST_WAIT,
        ST_DRAIN
    } bridge_state_e;

    typedef logic [1:0] opc_class_t;

    localparam opc_class_t OPC_EXEC = 2'b00;
    localparam opc_class_t OPC_LOAD = 2'b01;
    localparam opc_class_t OPC_READ = 2'b10;
    localparam opc_class_t OPC_RSVD = 2'b11;

    localparam logic [7:0] MAU_NOP = 8'h00;

endpackage

// File: rtl/mau_host_bridge_if.sv
// rtl/mau_host_bridge_if.sv - host byte streams and matrix-unit side signals of the bridge
interface mau_host_bridge_if;
    logic [7:0] s_data;
    logic       s_valid;
    logic       s_ready;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_ready;
    logic [7:0] mau_instruction;
    logic [7:0] mau_data_in;
    logic [7:0] mau_data_out;
    logic       mau_busy;

    modport master (
        output s_data, s_valid, m_ready, mau_data_out, mau_busy,
        input  s_ready, m_data, m_valid, mau_instruction, mau_data_in
    );

    modport slave (
        input  s_data, s_valid, m_ready, mau_data_out, mau_busy,
        output s_ready, m_data, m_valid, mau_instruction, mau_data_in
    );
endinterface

// File: rtl/mau_host_bridge_buf.sv
// rtl/mau_host_bridge_buf.sv - single-port matrix byte buffer, synchronous write, registered read
module mau_bridge_buf #(
    parameter int DEPTH = 64,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] addr,
    input  logic          we,
    input  logic [7:0]    wdata,
    input  logic          re,
    output logic [7:0]    rdata
);
    logic [7:0] mem [DEPTH];

    // Storage write; contents deliberately survive reset
    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata;
    end

    // Read register holds its value between reads so a stalled consumer sees stable data
    always_ff @(posedge clk) begin
        if (rst)     rdata <= 8'h00;
        else if (re) rdata <= mem[addr];
    end
endmodule

// File: rtl/mau_host_bridge.sv
// rtl/mau_host_bridge.sv - host-stream front end for the matrix unit; optional busy watchdog via MAU_BRIDGE_TIMEOUT_EN
module mau_host_bridge
    import mau_bridge_pkg::*;
#(
    parameter int MATRIX_DIM   = 8,
    parameter int RD_LAT       = 2,
    parameter int BUSY_TIMEOUT = 1023
) (
    input  logic              clk,
    input  logic              rst,
    mau_host_bridge_if.slave  bus,
    output logic              err
);
    localparam int N  = MATRIX_DIM * MATRIX_DIM;
    localparam int CW = $clog2(N + 1);
    localparam int AW = $clog2(N);
    localparam int LW = $clog2(RD_LAT + 1);
    localparam logic [CW-1:0] CNT_N    = CW'(N);
    localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);
    localparam logic [LW-1:0] LAT_INIT = LW'(RD_LAT - 1);

    bridge_state_e  state;
    logic [7:0]     opcode;
    logic [CW-1:0]  cnt;
    logic [LW-1:0]  lat_cnt;
    logic           s_ready_q;
    logic           m_valid_q;
    logic [7:0]     instr_q;
    logic           err_q;
    logic           timeout_hit;

    logic [AW-1:0]  buf_addr;
    logic           buf_we;
    logic           buf_re;
    logic [7:0]     buf_wdata;
    logic [7:0]     buf_rdata;

    wire accept  = bus.s_valid && s_ready_q;
    wire is_load = (opcode[7:6] == OPC_LOAD);
    wire is_read = (opcode[7:6] == OPC_READ);

    // Marker scope appears in the hierarchy only for out-of-range parameters:
    // capture needs at least one latency cycle and the watchdog limit must be nonzero.
    if (RD_LAT < 1 || BUSY_TIMEOUT < 1) begin : g_param_out_of_range
    end

`ifdef MAU_BRIDGE_TIMEOUT_EN
    localparam int WW = $clog2(BUSY_TIMEOUT + 1);
    localparam logic [WW-1:0] WD_LAST = WW'(BUSY_TIMEOUT - 1);
    logic [WW-1:0] wd_cnt;

    // Count consecutive busy cycles in WAIT; any other cycle restarts the count
    always_ff @(posedge clk) begin
        if (rst)                                   wd_cnt <= '0;
        else if (state == ST_WAIT && bus.mau_busy) wd_cnt <= wd_cnt + 1'b1;
        else                                       wd_cnt <= '0;
    end

    assign timeout_hit = (state == ST_WAIT) && bus.mau_busy && (wd_cnt == WD_LAST);
`else
    assign timeout_hit = 1'b0;
`endif

    // Buffer port steering; reads are issued one cycle before the byte is needed
    always_comb begin
        buf_addr  = '0;
        buf_we    = 1'b0;
        buf_re    = 1'b0;
        buf_wdata = bus.s_data;
        case (state)
            ST_FILL: begin
                buf_we   = accept;
                buf_addr = cnt[AW-1:0];
            end
            ST_ISSUE: begin
                buf_re = is_load;
            end
            ST_STREAM: begin
                buf_re   = (cnt != CNT_N);
                buf_addr = cnt[AW-1:0];
            end
            ST_CAPTURE: begin
                buf_we    = (lat_cnt == '0);
                buf_addr  = cnt[AW-1:0];
                buf_wdata = bus.mau_data_out;
            end
            ST_WAIT: begin
                buf_re = is_read && !bus.mau_busy && !timeout_hit;
            end
            ST_DRAIN: begin
                buf_re   = bus.m_ready && (cnt != CNT_LAST);
                buf_addr = cnt[AW-1:0] + 1'b1;
            end
            default: ;
        endcase
    end

    mau_bridge_buf #(.DEPTH(N), .AW(AW)) u_buf (
        .clk   (clk),
        .rst   (rst),
        .addr  (buf_addr),
        .we    (buf_we),
        .wdata (buf_wdata),
        .re    (buf_re),
        .rdata (buf_rdata)
    );

    // Packet sequencer with registered handshake, instruction and error outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            opcode    <= MAU_NOP;
            cnt       <= '0;
            lat_cnt   <= '0;
            s_ready_q <= 1'b0;
            m_valid_q <= 1'b0;
            instr_q   <= MAU_NOP;
            err_q     <= 1'b0;
        end else begin
            instr_q <= MAU_NOP;
            case (state)
                ST_IDLE: begin
                    s_ready_q <= 1'b1;
                    if (accept) begin
                        opcode <= bus.s_data;
                        cnt    <= '0;
                        case (bus.s_data[7:6])
                            OPC_EXEC, OPC_READ: begin
                                state     <= ST_ISSUE;
                                instr_q   <= bus.s_data;
                                s_ready_q <= 1'b0;
                            end
                            OPC_LOAD: state <= ST_FILL;
                            OPC_RSVD: err_q <= 1'b1;
                        endcase
                    end
                end
                ST_FILL: begin
                    if (accept) begin
                        cnt <= cnt + 1'b1;
                        if (cnt == CNT_LAST) begin
                            state     <= ST_ISSUE;
                            instr_q   <= opcode;
                            s_ready_q <= 1'b0;
                            cnt       <= '0;
                        end
                    end
                end
                ST_ISSUE: begin
                    if (is_load) begin
                        state <= ST_STREAM;
                        cnt   <= CW'(1);
                    end else if (is_read) begin
                        state   <= ST_CAPTURE;
                        cnt     <= '0;
                        lat_cnt <= LAT_INIT;
                    end else begin
                        state <= ST_WAIT;
                    end
                end
                ST_STREAM: begin
                    // cnt runs one ahead of the byte on mau_data_in
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_N) begin
                        state <= ST_WAIT;
                        cnt   <= '0;
                    end
                end
                ST_CAPTURE: begin
                    if (lat_cnt != '0) begin
                        lat_cnt <= lat_cnt - 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                        if (cnt == CNT_LAST) begin
                            state <= ST_WAIT;
                            cnt   <= '0;
                        end
                    end
                end
                ST_WAIT: begin
                    if (timeout_hit) begin
                        err_q     <= 1'b1;
                        state     <= ST_IDLE;
                        s_ready_q <= 1'b1;
                    end else if (!bus.mau_busy) begin
                        if (is_read) begin
                            state     <= ST_DRAIN;
                            m_valid_q <= 1'b1;
                            cnt       <= '0;
                        end else begin
                            state     <= ST_IDLE;
                            s_ready_q <= 1'b1;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (bus.m_ready) begin
                        if (cnt == CNT_LAST) begin
                            state     <= ST_IDLE;
                            m_valid_q <= 1'b0;
                            s_ready_q <= 1'b1;
                            cnt       <= '0;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // The buffer read register feeds both byte outputs; each is forced to zero outside its phase
    assign bus.s_ready         = s_ready_q;
    assign bus.m_valid         = m_valid_q;
    assign bus.m_data          = m_valid_q ? buf_rdata : 8'h00;
    assign bus.mau_instruction = instr_q;
    assign bus.mau_data_in     = (state == ST_STREAM) ? buf_rdata : 8'h00;
    assign err                 = err_q;
endmodule

// File: tb/tb_mau_host_bridge.sv
// tb/tb_mau_host_bridge.sv - directed self-checking bench for mau_host_bridge
module tb_mau_host_bridge;
    localparam int N = 64;

    logic clk = 1'b0;
    logic rst;
    logic err;
    int   n_checks = 0;
    int   n_fail   = 0;

    mau_host_bridge_if bus ();

    mau_host_bridge #(.MATRIX_DIM(8), .RD_LAT(2), .BUSY_TIMEOUT(1023)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus),
        .err (err)
    );

    always #5 clk = ~clk;

    // Matrix unit read model: first byte valid two cycles after the read instruction cycle
    logic read_seen;
    int   mdl_k;
    always @(posedge clk) begin
        if (rst) begin
            read_seen        <= 1'b0;
            mdl_k            <= N;
            bus.mau_data_out <= 8'h00;
        end else begin
            read_seen <= (bus.mau_instruction[7:6] == 2'b10);
            if (read_seen) begin
                bus.mau_data_out <= 8'hA0;
                mdl_k            <= 1;
            end else if (mdl_k < N) begin
                bus.mau_data_out <= 8'hA0 + 8'(mdl_k);
                mdl_k            <= mdl_k + 1;
            end else begin
                bus.mau_data_out <= 8'h00;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int guard = 0;
        bus.s_valid = 1'b1;
        bus.s_data  = b;
        while (bus.s_ready !== 1'b1 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        chk("send_accept_in_time", 32'(guard < 200), 1);
        @(negedge clk);
        bus.s_valid = 1'b0;
    endtask

    initial begin
        int nz;
        int hi;
        int idx;
        int guard;

        rst              = 1'b1;
        bus.s_valid      = 1'b0;
        bus.s_data       = 8'h00;
        bus.m_ready      = 1'b0;
        bus.mau_busy     = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_s_ready", bus.s_ready, 0);
        chk("rst_m_valid", bus.m_valid, 0);
        chk("rst_m_data", bus.m_data, 0);
        chk("rst_instr", bus.mau_instruction, 0);
        chk("rst_data_in", bus.mau_data_in, 0);
        chk("rst_err", err, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_s_ready", bus.s_ready, 1);

        // EXEC with the unit busy for several cycles
        bus.mau_busy = 1'b1;
        send_byte(8'h05);
        chk("exec_instr", bus.mau_instruction, 8'h05);
        chk("exec_s_ready_issue", bus.s_ready, 0);
        nz = 0;
        hi = 0;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            if (bus.mau_instruction !== 8'h00) nz++;
            if (bus.s_ready !== 1'b0) hi++;
        end
        chk("exec_instr_one_cycle", nz, 0);
        chk("exec_backpressure", hi, 0);
        bus.mau_busy = 1'b0;
        @(negedge clk);
        chk("exec_s_ready_after_busy", bus.s_ready, 1);

        // LOAD with random host gaps
        send_byte(8'h41);
        for (int k = 0; k < N; k++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            send_byte(8'(k));
        end
        chk("load_instr", bus.mau_instruction, 8'h41);
        nz = 0;
        for (int k = 0; k < N; k++) begin
            @(negedge clk);
            chk("stream_byte", bus.mau_data_in, k);
            if (bus.mau_instruction !== 8'h00) nz++;
        end
        chk("load_instr_one_cycle", nz, 0);
        @(negedge clk);
        chk("stream_end_zero", bus.mau_data_in, 0);

        // READ drained with m_ready toggling
        send_byte(8'h82);
        chk("read_instr", bus.mau_instruction, 8'h82);
        idx   = 0;
        guard = 0;
        while (idx < N && guard < 600) begin
            @(negedge clk);
            guard++;
            bus.m_ready = ~bus.m_ready;
            if (bus.m_valid === 1'b1) begin
                chk("drain_byte", bus.m_data, 32'(8'hA0 + idx));
                if (bus.m_ready) idx++;
            end
        end
        chk("drain_count", idx, N);
        @(negedge clk);
        bus.m_ready = 1'b0;
        chk("drain_m_valid_done", bus.m_valid, 0);
        chk("drain_s_ready_done", bus.s_ready, 1);

        // Reserved opcode, then EXEC still works and err stays set
        send_byte(8'hC3);
        chk("rsvd_err", err, 1);
        chk("rsvd_s_ready", bus.s_ready, 1);
        chk("rsvd_no_instr", bus.mau_instruction, 0);
        send_byte(8'h05);
        chk("post_rsvd_instr", bus.mau_instruction, 8'h05);
        chk("post_rsvd_err", err, 1);
        repeat (2) @(negedge clk);

        // Reset in the middle of STREAM
        send_byte(8'h41);
        for (int k = 0; k < N; k++) send_byte(8'(8'h80 + k));
        chk("rst_load_instr", bus.mau_instruction, 8'h41);
        repeat (31) @(negedge clk);
        chk("rst_stream_byte30", bus.mau_data_in, 8'h9E);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_s_ready", bus.s_ready, 0);
        chk("midrst_m_valid", bus.m_valid, 0);
        chk("midrst_m_data", bus.m_data, 0);
        chk("midrst_instr", bus.mau_instruction, 0);
        chk("midrst_data_in", bus.mau_data_in, 0);
        chk("midrst_err", err, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_idle_ready", bus.s_ready, 1);
        send_byte(8'h07);
        chk("midrst_exec_instr", bus.mau_instruction, 8'h07);
        repeat (2) @(negedge clk);
        chk("midrst_back_idle", bus.s_ready, 1);

`ifdef MAU_BRIDGE_TIMEOUT_EN
        bus.mau_busy = 1'b1;
        send_byte(8'h09);
        @(negedge clk);
        guard = 0;
        while (err !== 1'b1 && guard < 1100) begin
            @(negedge clk);
            guard++;
        end
        chk("timeout_cycles", guard, 1023);
        chk("timeout_s_ready", bus.s_ready, 1);
        bus.mau_busy = 1'b0;
        @(negedge clk);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/mau_host_bridge.md
# mau_host_bridge

Byte-stream front end that sits directly upstream of the matrix algebra unit and drives its `host_instruction` and `data_in` inputs, and reads back its `data_out` byte port. It decodes opcode packets from a valid/ready host stream, buffers a full matrix before a load, issues the instruction, and streams the bytes at one per cycle. It also captures read-back bytes into the same buffer and drains them to an output stream with backpressure. It waits on the unit's busy flag so that the host never has to track unit timing.

## Interface
- `MATRIX_DIM`, 8: matrix side; N = MATRIX_DIM*MATRIX_DIM bytes per matrix.
- `RD_LAT`, 2: cycles from read-instruction cycle to first valid `mau_data_out` byte.
- `BUSY_TIMEOUT`, 1023: watchdog limit in cycles (only with macro).

Ports:
- `clk` in 1: the single clock. One clock; all logic on its rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `s_data` in 8: host byte in.
- `s_valid` in 1: host byte valid.
- `s_ready` out 1: bridge accepts the byte.
- `m_data` out 8: read-back byte to host.
- `m_valid` out 1: read-back byte valid.
- `m_ready` in 1: host accepts the byte.
- `mau_instruction` out 8: to unit `host_instruction`; 8'h00 = NOP.
- `mau_data_in` out 8: to unit `data_in`.
- `mau_data_out` in 8: from unit `data_out`.
- `mau_busy` in 1: from unit `busy_flag`.
- `err` out 1: sticky error; cleared only by `rst`.

## Operation
- Opcode class is `s_data[7:6]`:
  - 00 = EXEC: issue the byte as-is.
  - 01 = LOAD: N data bytes follow.
  - 10 = READ: N bytes are returned.
  - 11 = reserved: the byte is consumed and dropped, `err` is set, and the state stays IDLE.
- States:
  - IDLE (`s_ready`=1): accept an opcode and latch it.
    - EXEC → ISSUE.
    - LOAD → FILL.
    - READ → ISSUE.
  - FILL (`s_ready`=1): write each accepted byte to buffer[cnt] and increment cnt. After byte N-1 → ISSUE.
  - ISSUE: drive the latched opcode on `mau_instruction` for exactly one cycle.
    - LOAD → STREAM.
    - READ → CAPTURE.
    - EXEC → WAIT.
  - STREAM: `mau_data_in` = buffer[k] for k = 0..N-1 on consecutive cycles, no gaps → WAIT.
  - CAPTURE: buffer[k] ← `mau_data_out` on cycles ISSUE+RD_LAT+k, for k = 0..N-1 → WAIT.
  - WAIT: minimum 1 cycle; leave on the first cycle `mau_busy`=0.
    - READ → DRAIN.
    - Otherwise → IDLE.
  - DRAIN: `m_valid`=1 with `m_data`=buffer[k]; k advances on `m_valid && m_ready`. After byte N-1 is accepted → IDLE.
- `s_ready`=0 in all states except IDLE and FILL, so the host is backpressured during execution.
- `mau_instruction`=0 and `mau_data_in`=0 whenever not in ISSUE or STREAM respectively.
- Counter width is clog2(N+1). Wrap at N is an error-free reset to 0 on state exit.
- A LOAD with N=64 stalls in FILL indefinitely if the host stops; no timeout applies in FILL.

## Timing
- Reset values: `s_ready`=0 in the reset cycle, then 1 in IDLE. `m_valid`=0, `m_data`=0, `mau_instruction`=0, `mau_data_in`=0, `err`=0, state=IDLE.
- Buffer contents are not cleared by reset.
- Reset mid-operation aborts immediately. Partial loads are discarded, and the unit may be left mid-operation; the system resets both together.
- The opcode is accepted at cycle t:
  - EXEC issues at t+1.
  - READ issues at t+1.
  - LOAD issues at the cycle after the N-th data byte is accepted; the first data byte appears on `mau_data_in` the next cycle.
- Back-to-back packets: a new opcode can be accepted in the first IDLE cycle after WAIT or DRAIN completes.
- `m_data` is registered; it is stable while `m_valid && !m_ready`.

## Configuration
- With `MAU_BRIDGE_TIMEOUT_EN` defined:
  - In WAIT, a counter runs while `mau_busy`=1.
  - On reaching BUSY_TIMEOUT, the bridge sets `err` and goes → IDLE, skipping DRAIN.
- Without the macro:
  - WAIT blocks until busy drops.
  - No counter logic is present.
  - `BUSY_TIMEOUT` is ignored.

## Structure
- Package `mau_bridge_pkg` holds:
  - the state enum;
  - opcode class constants `OPC_EXEC`, `OPC_LOAD`, `OPC_READ`, `OPC_RSVD`;
  - `MAU_NOP` = 8'h00.
- Sub-module `mau_bridge_buf`: N×8 single-port byte buffer with synchronous write and registered read.
  - Read is issued one cycle ahead in STREAM and DRAIN, so there is no bubble.
- The FSM, counters and watchdog live in the top level.

## Test plan
- EXEC 8'h05 sent in IDLE → `mau_instruction`=8'h05 for exactly 1 cycle. Hold `mau_busy`=1 for 10 cycles → `s_ready` low until busy drops, then high.
- LOAD 8'h41 + bytes 0..63 with random `s_valid` gaps → one cycle of 8'h41, then `mau_data_in` = 0,1,…,63 on 64 consecutive cycles.
- READ 8'h82 with a unit model returning 8'hA0+k at RD_LAT=2 → `m_data` sequence A0..DF. With `m_ready` toggling every other cycle, no byte is lost or duplicated.
- Reserved 8'hC3 → byte consumed, `err`=1, no instruction issued. A following EXEC still works; `err` stays 1.
- `rst` asserted at byte 30 of STREAM → next cycle all outputs are at reset values and state is IDLE.
- With `MAU_BRIDGE_TIMEOUT_EN`: `mau_busy` held at 1 → `err`=1 after 1023 WAIT cycles, and IDLE with `s_ready`=1 the next cycle.
